// File: rtl/digit_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_stream_ctrl
// Brief    : Serial binary-to-BCD conversion, then glyph-ROM byte streaming
//            MS digit first over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module digit_stream_ctrl #(
    parameter int VALUE_W     = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int GLYPH_BYTES = 135,
    parameter bit LEAD_BLANK  = 1'b1,
    localparam int c_dig_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [3:0]         rom_number,
    output logic [7:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_first,
    output logic               out_last,
    output logic [c_dig_w-1:0] digit_idx
);

    localparam int c_bcd_w = 4 * NUM_DIGITS;
    localparam int c_cnt_w = $clog2(VALUE_W + 1);
    localparam int c_max_int = 10 ** NUM_DIGITS - 1;
    localparam logic [VALUE_W:0]     c_max_val   = c_max_int[VALUE_W:0];
    localparam logic [7:0]           c_last_addr = 8'(GLYPH_BYTES - 1);
    localparam logic [c_dig_w-1:0]   c_last_dig  = c_dig_w'(NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_end   = c_cnt_w'(VALUE_W);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_conv   = 3'd1;
    localparam logic [2:0] c_load   = 3'd2;
    localparam logic [2:0] c_stream = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [VALUE_W-1:0] r_bin;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_bcd_w-1:0] w_bcd_adj;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf;
    logic [7:0]         r_addr;
    logic [c_dig_w-1:0] r_dig;
    logic [c_dig_w-1:0] w_next_dig;
    logic [c_dig_w-1:0] w_rom_dig;
    logic               w_stream;
    logic               w_accept;
    logic               w_wrap;
    logic               w_lead;
    logic [3:0]         w_digit [NUM_DIGITS];
    logic [3:0]         w_code  [NUM_DIGITS];

    assign w_stream   = (r_state == c_stream);
    assign w_accept   = w_stream && out_ready;
    assign w_wrap     = (r_addr == c_last_addr);
    assign w_next_dig = (r_dig == c_last_dig) ? '0 : r_dig + c_dig_w'(1);
    assign w_rom_dig  = (w_accept && w_wrap) ? w_next_dig : r_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:   if (start) w_next_state = c_conv;
            c_conv:   if (r_cnt == c_cnt_end) w_next_state = c_load;
            c_load:   w_next_state = c_stream;
            c_stream: if (w_accept && w_wrap && (r_dig == c_last_dig)) w_next_state = c_done;
            c_done:   w_next_state = c_idle;
            default:  w_next_state = c_idle;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_idle);
        done       = (r_state == c_done);
        overflow   = r_ovf;
        out_valid  = w_stream;
        out_data   = w_stream ? rom_data : 8'd0;
        out_first  = w_stream && (r_dig == '0) && (r_addr == 8'd0);
        out_last   = w_stream && (r_dig == c_last_dig) && w_wrap;
        digit_idx  = r_dig;
        rom_addr   = w_accept ? (w_wrap ? 8'd0 : r_addr + 8'd1) : r_addr;
        rom_number = ((r_state == c_load) || w_stream) ? w_code[w_rom_dig] : 4'd0;
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Digit 0 is the MS digit; a digit blanks only while every digit above it is zero.
    always_comb begin
        w_lead = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i] = r_ovf ? 4'd9 : r_bcd[(NUM_DIGITS-1-i)*4 +: 4];
            w_lead     = w_lead && (w_digit[i] == 4'd0);
            w_code[i]  = (LEAD_BLANK && w_lead && (i != NUM_DIGITS - 1)) ? 4'hF : w_digit[i];
        end
    end

    // Conversion cycle 0 range-checks the captured value; the rest are shift+add-3 steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_bin <= value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                c_conv: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == '0) begin
                        r_ovf <= ({1'b0, r_bin} > c_max_val);
                    end else begin
                        r_bcd <= {w_bcd_adj[c_bcd_w-2:0], r_bin[VALUE_W-1]};
                        r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
                        // A bit leaving the top digit also means the value did not fit.
                        r_ovf <= r_ovf | w_bcd_adj[c_bcd_w-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Address of the byte currently on rom_data; it only advances on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 8'd0;
            r_dig  <= '0;
        end else if (w_accept) begin
            if (w_wrap) begin
                r_addr <= 8'd0;
                r_dig  <= w_next_dig;
            end else begin
                r_addr <= r_addr + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_stream_ctrl
// Brief    : Directed self-checking bench for digit_stream_ctrl with a
//            registered glyph ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_stream_ctrl;

    localparam int c_gb = 135;
    localparam int c_nb = 4 * c_gb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  rom_number;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic [1:0]  digit_idx;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    digit_stream_ctrl #(
        .VALUE_W    (14),
        .NUM_DIGITS (4),
        .GLYPH_BYTES(c_gb),
        .LEAD_BLANK (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .rom_number(rom_number),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .digit_idx (digit_idx)
    );

    function automatic logic [7:0] glyph(input logic [3:0] n, input logic [7:0] a);
        if (n == 4'hF) return 8'h00;
        if (n > 4'd9)  return 8'hEE;
        return 8'(int'(n) * 29 + int'(a) * 7 + 1);
    endfunction

    always_ff @(posedge clk) rom_data <= glyph(rom_number, rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // codes holds the expected ROM code per digit, MS digit in the top nibble.
    task automatic run_frame(input string tag, input logic [13:0] v, input logic [15:0] codes,
                             input logic exp_ovf, input int ready_pct, input int exp_lat,
                             input bit inject, input int abort_at);
        int         nbytes    = 0;
        int         cyc       = 0;
        int         first_cyc = -1;
        int         done_cnt  = 0;
        int         byte_err  = 0;
        int         flag_err  = 0;
        int         stall_err = 0;
        int         extra     = 0;
        int         d;
        bit         fin       = 1'b0;
        bit         aborted   = 1'b0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic       ovf_done   = 1'b0;
        logic [3:0] code;
        @(negedge clk);
        value = v;
        start = 1'b1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            out_ready = ($urandom_range(99) < ready_pct);
            if (inject && nbytes == 100) start = 1'b1;
            #1;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            if (abort_at >= 0 && nbytes == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " reset outputs"},
                      {busy, done, overflow, out_valid, out_first, out_last,
                       rom_number, rom_addr, digit_idx, out_data}, '0);
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (done) begin
                    done_cnt++;
                    ovf_done = overflow;
                    fin = 1'b1;
                    if (inject) start = 1'b1;
                end
                if (out_valid && out_ready) begin
                    d    = nbytes / c_gb;
                    code = codes[15 - 4*d -: 4];
                    if (out_data !== glyph(code, 8'(nbytes % c_gb))) byte_err++;
                    if (out_first !== (nbytes == 0)) flag_err++;
                    if (out_last !== (nbytes == c_nb - 1)) flag_err++;
                    if (digit_idx !== 2'(d)) flag_err++;
                    nbytes++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
        check({tag, " finished"}, 32'(fin), 32'd1);
        if (aborted) begin
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) begin
                @(negedge clk);
                #1;
                if (done || busy || out_valid) extra++;
            end
            check({tag, " no done after abort"}, 32'(extra), 32'd0);
        end else begin
            check({tag, " byte count"}, 32'(nbytes), 32'(c_nb));
            check({tag, " byte errors"}, 32'(byte_err), 32'd0);
            check({tag, " flag errors"}, 32'(flag_err), 32'd0);
            check({tag, " stall errors"}, 32'(stall_err), 32'd0);
            check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
            check({tag, " overflow"}, 32'(ovf_done), 32'(exp_ovf));
            if (exp_lat >= 0) check({tag, " latency"}, 32'(first_cyc), 32'(exp_lat));
            @(negedge clk);
            start = 1'b0;
            #1;
            check({tag, " busy after done"}, 32'(busy), 32'd0);
            if (inject) begin
                repeat (20) begin
                    @(negedge clk);
                    #1;
                    if (busy || out_valid || done) extra++;
                end
                check({tag, " no second frame"}, 32'(extra), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        value     = 14'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset state",
              {busy, done, overflow, out_valid, out_first, out_last,
               rom_number, rom_addr, digit_idx, out_data}, '0);
        rst_n = 1'b1;

        run_frame("t1 1234",     14'd1234,  16'h1234, 1'b0, 100, 17, 1'b0, -1);
        run_frame("t2 7",        14'd7,     16'hFFF7, 1'b0, 100, -1, 1'b0, -1);
        run_frame("t2 0",        14'd0,     16'hFFF0, 1'b0, 100, -1, 1'b0, -1);
        run_frame("t3 12000",    14'd12000, 16'h9999, 1'b1, 100, -1, 1'b0, -1);
        check("t3 overflow held", 32'(overflow), 32'd1);
        run_frame("t3 5",        14'd5,     16'hFFF5, 1'b0, 100, -1, 1'b0, -1);
        run_frame("t4 8086",     14'd8086,  16'h8086, 1'b0, 50,  -1, 1'b0, -1);
        run_frame("t5 305",      14'd305,   16'hF305, 1'b0, 100, -1, 1'b1, -1);
        run_frame("t6 abort",    14'd4321,  16'h4321, 1'b0, 100, -1, 1'b0, 300);
        run_frame("t6 9999",     14'd9999,  16'h9999, 1'b0, 100, 17, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
